// File: rtl/mem_byte_arb.sv
// ============================================================================
// Module   : mem_byte_arb
// Brief    : Two-port arbiter/sequencer for a byte-masked 256x32 sync memory.
//            Define MEM_BYTE_ARB_RR_EN for round-robin; default is fixed
//            priority with port 0 winning.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_byte_arb #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRESS   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_wr,
  input  logic [3:0]           req_mask0,
  input  logic [3:0]           req_mask1,
  input  logic [ADDRESS-1:0]   req_addr0,
  input  logic [ADDRESS-1:0]   req_addr1,
  input  logic [DATAWIDTH-1:0] req_wdata0,
  input  logic [DATAWIDTH-1:0] req_wdata1,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic [3:0]           mem_wr_mask,
  output logic [ADDRESS-1:0]   mem_addr,
  output logic [DATAWIDTH-1:0] mem_wr_data,
  input  logic [DATAWIDTH-1:0] mem_r_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_owner;
  logic [DATAWIDTH-1:0] r_rdata;

  logic                 w_take;
  logic                 w_out_en;
  logic                 w_gnt;
  logic                 w_sel_wr;

`ifdef MEM_BYTE_ARB_RR_EN
  logic                 r_last;

  always_comb begin
    if (req_valid == 2'b11) w_gnt = ~r_last;
    else                    w_gnt = req_valid[1];
  end
`else
  assign w_gnt = ~req_valid[0];
`endif

  assign w_take   = (r_state == IDLE) && (|req_valid);
  // Outputs are forced quiet while reset is held, even though IDLE is active.
  assign w_out_en = w_take && rst_n;
  assign w_sel_wr = w_gnt ? req_wr[1] : req_wr[0];

  always_comb begin
    req_ready   = 2'b00;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_wr_mask = 4'b0000;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (w_out_en) begin
      req_ready   = w_gnt ? 2'b10 : 2'b01;
      mem_en      = 1'b1;
      mem_wr      = w_sel_wr;
      mem_wr_mask = w_sel_wr ? (w_gnt ? req_mask1 : req_mask0) : 4'b0000;
      mem_addr    = w_gnt ? req_addr1 : req_addr0;
      mem_wr_data = w_gnt ? req_wdata1 : req_wdata0;
    end
  end

  assign rsp_valid = (r_state == RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = (r_state == RESP) ? r_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_rdata <= '0;
`ifdef MEM_BYTE_ARB_RR_EN
      r_last  <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
`ifdef MEM_BYTE_ARB_RR_EN
            r_last <= w_gnt;
`endif
            if (!w_sel_wr) begin
              r_owner <= w_gnt;
              r_state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          r_rdata <= mem_r_data;
          r_state <= RESP;
        end
        RESP: begin
          if (rsp_ready[r_owner]) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_byte_arb.sv
// ============================================================================
// Module   : tb_mem_byte_arb
// Brief    : Directed self-checking bench for mem_byte_arb with a behavioural
//            byte-masked memory model attached to the memory pins.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_byte_arb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_wr;
  logic [3:0]  req_mask0, req_mask1;
  logic [7:0]  req_addr0, req_addr1;
  logic [31:0] req_wdata0, req_wdata1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_wr;
  logic [3:0]  mem_wr_mask;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_r_data;

  int checks = 0;
  int errors = 0;

  mem_byte_arb #(.DATAWIDTH(32), .ADDRESS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_mask0(req_mask0), .req_mask1(req_mask1),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_wr_mask(mem_wr_mask),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_r_data(mem_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: byte-masked write, registered read.
  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem_r_data = 32'h0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr) begin
        for (int b = 0; b < 4; b++)
          if (mem_wr_mask[b]) mem[mem_addr][b*8 +: 8] <= mem_wr_data[b*8 +: 8];
      end else begin
        mem_r_data <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_req(input logic p, input logic wr, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    if (p) begin
      req_wr[1] = wr; req_addr1 = a; req_wdata1 = d; req_mask1 = m;
    end else begin
      req_wr[0] = wr; req_addr0 = a; req_wdata0 = d; req_mask0 = m;
    end
  endtask

  task automatic do_write(input logic p, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    set_req(p, 1'b1, a, d, m);
    req_valid = p ? 2'b10 : 2'b01;
    #1;
    chk("wr_ready", req_ready, p ? 2'b10 : 2'b01);
    chk("wr_en",    mem_en, 1);
    chk("wr_wr",    mem_wr, 1);
    chk("wr_addr",  mem_addr, a);
    chk("wr_mask",  mem_wr_mask, m);
    chk("wr_data",  mem_wr_data, d);
    @(posedge clk); #1;
    req_valid = 2'b00;
  endtask

  task automatic do_read(input logic p, input logic [7:0] a, input logic [31:0] exp);
    @(negedge clk);
    set_req(p, 1'b0, a, 32'hFFFF_FFFF, 4'hF);
    req_valid = p ? 2'b10 : 2'b01;
    #1;
    chk("rd_ready", req_ready, p ? 2'b10 : 2'b01);
    chk("rd_en",    mem_en, 1);
    chk("rd_wr",    mem_wr, 0);
    chk("rd_mask",  mem_wr_mask, 0);
    chk("rd_addr",  mem_addr, a);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("rdwait_valid", rsp_valid, 0);
    chk("rdwait_en",    mem_en, 0);
    @(negedge clk);
    chk("resp_valid", rsp_valid, p ? 2'b10 : 2'b01);
    chk("resp_data",  rsp_rdata, exp);
    rsp_ready = p ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("post_valid", rsp_valid, 0);
    chk("post_data",  rsp_rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; req_wr = 2'b00; rsp_ready = 2'b00;
    req_mask0 = 0; req_mask1 = 0; req_addr0 = 0; req_addr1 = 0;
    req_wdata0 = 0; req_wdata1 = 0;

    // Outputs held quiet during reset even with a pending request.
    set_req(1'b0, 1'b1, 8'h10, 32'hCAFE_F00D, 4'hF);
    req_valid = 2'b01;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_en",    mem_en, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    do_write(1'b0, 8'h10, 32'hA1B2C3D4, 4'b1111);
    do_read (1'b0, 8'h10, 32'hA1B2C3D4);
    do_write(1'b0, 8'h10, 32'h11223344, 4'b0101);
    do_read (1'b0, 8'h10, 32'hA122C344);
    do_write(1'b0, 8'h10, 32'h99999999, 4'b0000);
    do_read (1'b0, 8'h10, 32'hA122C344);
    do_write(1'b0, 8'h30, 32'h00000055, 4'b0001);
    do_read (1'b0, 8'h30, 32'h00000055);

    // Port 1 read held in RESP while port 0 waits with a write.
    @(negedge clk);
    set_req(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    req_valid = 2'b10;
    #1;
    chk("hold_ready", req_ready, 2'b10);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 8'h40, 32'hDEADBEEF, 4'hF);
    req_valid = 2'b01;
    @(negedge clk);
    chk("hold_rdwait_ready", req_ready, 0);
    @(negedge clk);
    chk("hold_valid0", rsp_valid, 2'b10);
    chk("hold_data0",  rsp_rdata, 32'hA122C344);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 2'b10);
      chk("hold_data",  rsp_rdata, 32'hA122C344);
      chk("hold_ready_lo", req_ready, 0);
    end
    rsp_ready = 2'b10;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("after_hs_valid", rsp_valid, 0);
    chk("after_hs_ready", req_ready, 2'b01);
    chk("after_hs_addr",  mem_addr, 8'h40);
    @(posedge clk); #1;
    req_valid = 2'b00;

    // Reset pulsed while in RD_WAIT drops the read.
    @(negedge clk);
    set_req(1'b0, 1'b0, 8'h10, 32'h0, 4'h0);
    req_valid = 2'b01;
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 8'h50, 32'h12345678, 4'hF);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_en",    mem_en, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_rdata", rsp_rdata, 0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("postrst_ready", req_ready, 2'b01);
    chk("postrst_addr",  mem_addr, 8'h50);
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_no_rsp", rsp_valid, 0);
    end
    do_read(1'b0, 8'h50, 32'h12345678);

    // Contention from a fresh reset: both ports hold writes for 4 cycles.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1'b0, 1'b1, 8'h20, 32'h0000AAAA, 4'hF);
    set_req(1'b1, 1'b1, 8'h21, 32'h0000BBBB, 4'hF);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_g;
`ifdef MEM_BYTE_ARB_RR_EN
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b01;
`endif
      #1;
      chk("arb_ready", req_ready, exp_g);
      chk("arb_addr",  mem_addr, (exp_g == 2'b01) ? 8'h20 : 8'h21);
      @(negedge clk);
    end
    req_valid = 2'b00;
`ifdef MEM_BYTE_ARB_RR_EN
    do_read(1'b1, 8'h21, 32'h0000BBBB);
`else
    do_read(1'b1, 8'h21, 32'h00000000);
`endif
    do_read(1'b0, 8'h20, 32'h0000AAAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
